// File: rtl/nios2_pio_pkg.sv
// Shared constants for the UART RX parallel-input port: Avalon register
// addresses, edge-type selectors and the edge detector itself.
package nios2_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_DIR     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Operates on a full 32-bit word; callers slice down to their width.
    function automatic logic [31:0] f_edge_det(input logic [31:0] cur,
                                               input logic [31:0] prev,
                                               input int          etype);
        case (etype)
            EDGE_FALL: f_edge_det = ~cur & prev;
            EDGE_ANY:  f_edge_det = cur ^ prev;
            default:   f_edge_det = cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/nios2_pio_sync.sv
// Multi-flop synchronizer for the asynchronous parallel input; the last
// stage is the only one the rest of the block may look at.
module nios2_pio_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/nios2_uart_rx_pi.sv
// Avalon-MM parallel-input port with edge capture for the UART RX status lines.
// Interrupt mask and irq are only built when NIOS2_UART_RX_PI_IRQ_EN is defined.
module nios2_uart_rx_pi
    import nios2_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] w_sync_q;
    logic [DATA_WIDTH-1:0] r_prev_q;
    logic [DATA_WIDTH-1:0] w_edge_det;
    logic [DATA_WIDTH-1:0] r_edge_cap;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [31:0]           w_edge_full;
    logic                  w_wr;

    nios2_pio_sync #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_d     (in_port),
        .o_q     (w_sync_q)
    );

    assign w_edge_full = f_edge_det(32'(w_sync_q), 32'(r_prev_q), EDGE_TYPE);
    assign w_edge_det  = w_edge_full[DATA_WIDTH-1:0];
    assign w_wr        = chipselect & ~write_n;
    assign w_clr       = (w_wr && address == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;

    // A fresh edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_q   <= '0;
            r_edge_cap <= '0;
        end else begin
            r_prev_q   <= w_sync_q;
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge_det;
        end
    end

`ifdef NIOS2_UART_RX_PI_IRQ_EN
    logic [DATA_WIDTH-1:0] r_irqmask;
    logic                  r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqmask <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr && address == ADDR_IRQMASK) begin
                r_irqmask <= writedata[DATA_WIDTH-1:0];
            end
            r_irq <= |(r_edge_cap & r_irqmask);
        end
    end

    assign w_mask = r_irqmask;
    assign irq    = r_irq;
`else
    assign w_mask = '0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:    readdata[DATA_WIDTH-1:0] = w_sync_q;
                ADDR_IRQMASK: readdata[DATA_WIDTH-1:0] = w_mask;
                ADDR_EDGECAP: readdata[DATA_WIDTH-1:0] = r_edge_cap;
                default:      readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_uart_rx_pi.sv
// Directed bench for nios2_uart_rx_pi: a 32-bit rising-edge instance and an
// 8-bit any-edge instance sharing one Avalon bus.
module tb_nios2_uart_rx_pi;
    import nios2_pio_pkg::*;

`ifdef NIOS2_UART_RX_PI_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] in_port;
    logic        irq;
    logic [31:0] readdata2;
    logic [7:0]  in_port2;
    logic        irq2;

    int n_chk = 0;
    int n_err = 0;

    nios2_uart_rx_pi u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    nios2_uart_rx_pi #(
        .DATA_WIDTH  (8),
        .EDGE_TYPE   (2),
        .SYNC_STAGES (2)
    ) u_dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata2),
        .in_port    (in_port2),
        .irq        (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        tick();
        write_n   = 1'b1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic rd2_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata2, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ADDR_DATA;
        writedata  = '0;
        in_port    = '0;
        in_port2   = '0;
        repeat (3) tick();
        chipselect = 1'b1;
        rd_chk("rst_data", ADDR_DATA, 32'h0);
        rd_chk("rst_ecap", ADDR_EDGECAP, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // Release reset with A5 already on the pins.
        reset_n = 1'b1;
        in_port = 32'hA5;
        address = ADDR_DATA;
        tick();
        rd_chk("sync_edge1", ADDR_DATA, 32'h0);
        tick();
        rd_chk("sync_edge2", ADDR_DATA, 32'hA5);
        rd_chk("ecap_edge2", ADDR_EDGECAP, 32'h0);
        tick();
        rd_chk("ecap_held_hi", ADDR_EDGECAP, 32'hA5);
        wr(ADDR_EDGECAP, 32'hFFFF_FFFF);
        rd_chk("ecap_init_clr", ADDR_EDGECAP, 32'h0);

        // Bit 3 rising.
        in_port = 32'hAD;
        tick();
        tick();
        rd_chk("b3_before_cap", ADDR_EDGECAP, 32'h0);
        tick();
        rd_chk("b3_cap", ADDR_EDGECAP, 32'h8);
        rd_chk("data_ad", ADDR_DATA, 32'hAD);
        rd_chk("dir_rd", ADDR_DIR, 32'h0);
        wr(ADDR_DIR, 32'hFFFF_FFFF);
        rd_chk("dir_wr_ign", ADDR_DIR, 32'h0);
        wr(ADDR_DATA, 32'h1234_5678);
        rd_chk("data_wr_ign", ADDR_DATA, 32'hAD);
        wr(ADDR_EDGECAP, 32'h0);
        rd_chk("clr_zero", ADDR_EDGECAP, 32'h8);
        wr(ADDR_EDGECAP, 32'h4);
        rd_chk("clr_other", ADDR_EDGECAP, 32'h8);
        wr(ADDR_EDGECAP, 32'h8);
        rd_chk("clr_b3", ADDR_EDGECAP, 32'h0);
        chipselect = 1'b0;
        address    = ADDR_DATA;
        #1;
        chk("cs_low", readdata, 32'h0);
        chipselect = 1'b1;

        // Falling edges are ignored by the rising-edge instance.
        in_port = 32'hA5;
        repeat (4) tick();
        rd_chk("no_fall", ADDR_EDGECAP, 32'h0);

        // Clear lands on the same edge as a new bit 3 detection.
        in_port = 32'hAD;
        tick();
        tick();
        wr(ADDR_EDGECAP, 32'h8);
        rd_chk("collide", ADDR_EDGECAP, 32'h8);
        wr(ADDR_EDGECAP, 32'h8);
        rd_chk("collide_clr", ADDR_EDGECAP, 32'h0);

        // Interrupt path; the default build reads mask 0 and never raises irq.
        wr(ADDR_IRQMASK, 32'hFFFF_FFFF);
        rd_chk("mask_all", ADDR_IRQMASK, IRQ_ON ? 32'hFFFF_FFFF : 32'h0);
        wr(ADDR_IRQMASK, 32'h8);
        rd_chk("mask_b3", ADDR_IRQMASK, IRQ_ON ? 32'h8 : 32'h0);
        in_port = 32'hA5;
        repeat (3) tick();
        in_port = 32'hAD;
        repeat (3) tick();
        chk("irq_at_cap", {31'b0, irq}, 32'h0);
        tick();
        chk("irq_rise", {31'b0, irq}, IRQ_ON ? 32'h1 : 32'h0);
        wr(ADDR_EDGECAP, 32'h8);
        chk("irq_clr_edge", {31'b0, irq}, IRQ_ON ? 32'h1 : 32'h0);
        tick();
        chk("irq_fall", {31'b0, irq}, 32'h0);
        wr(ADDR_IRQMASK, 32'h0);
        in_port = 32'hA5;
        repeat (3) tick();
        in_port = 32'hAD;
        repeat (4) tick();
        rd_chk("mask0_cap", ADDR_EDGECAP, 32'h8);
        chk("mask0_irq", {31'b0, irq}, 32'h0);

        // Any-edge, 8-bit instance: 1-0-1 pulse on bit 0.
        wr(ADDR_EDGECAP, 32'hFFFF_FFFF);
        in_port2 = 8'h01;
        repeat (3) tick();
        rd2_chk("any_rise", ADDR_EDGECAP, 32'h1);
        wr(ADDR_EDGECAP, 32'h1);
        rd2_chk("any_clr", ADDR_EDGECAP, 32'h0);
        in_port2 = 8'h00;
        repeat (3) tick();
        rd2_chk("any_fall", ADDR_EDGECAP, 32'h1);
        in_port2 = 8'h01;
        repeat (3) tick();
        rd2_chk("any_rise2", ADDR_EDGECAP, 32'h1);
        in_port2 = 8'hF1;
        repeat (3) tick();
        rd2_chk("w8_data", ADDR_DATA, 32'h0000_00F1);
        rd2_chk("w8_ecap", ADDR_EDGECAP, 32'h0000_00F1);

        // Asynchronous reset in the middle of activity.
        in_port2 = 8'h00;
        tick();
        reset_n = 1'b0;
        #1;
        rd2_chk("arst_data2", ADDR_DATA, 32'h0);
        rd2_chk("arst_ecap2", ADDR_EDGECAP, 32'h0);
        rd_chk("arst_data", ADDR_DATA, 32'h0);
        rd_chk("arst_ecap", ADDR_EDGECAP, 32'h0);
        rd_chk("arst_mask", ADDR_IRQMASK, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        chk("arst_irq2", {31'b0, irq2}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/nios2_uart_rx_pi.md
NIOS2_UART_RX_PI -- requirements
Module: nios2_uart_rx_pi

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the in_port width; valid range is 1..32.
REQ-003 Parameter EDGE_TYPE, default 0, SHALL select the captured edge: 0 = rising, 1 = falling, 2 = any.
REQ-004 Parameter SYNC_STAGES, default 2, SHALL set the input synchronizer depth; valid range is 2..4.
REQ-005 clk  input  1  system clock, all registers rising-edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, zero wait states, zero read latency.
REQ-012 in_port  input  DATA_WIDTH  asynchronous parallel input from the UART RX logic.
REQ-013 irq  output  1  level interrupt, active high.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-015 A change on in_port sampled at clock edge k SHALL appear in sync_q after edge k+SYNC_STAGES-1.
REQ-016 A prev_q register SHALL hold sync_q delayed by one clock; edge_det[i] SHALL be sync_q&~prev_q (rising), ~sync_q&prev_q (falling) or sync_q^prev_q (any).
REQ-017 edge_cap[i] SHALL set on the clock after edge_det[i] is high and hold until cleared.
REQ-018 Register map, with readdata driven combinationally from address whenever chipselect is high.
- 0 data: read sync_q, zero-extended; writes ignored.
- 1 direction: reads 0; writes ignored.
- 2 irqmask: read/write, DATA_WIDTH bits.
- 3 edgecapture: reads edge_cap; writing 1 to bit i clears bit i, writing 0 leaves it unchanged.
REQ-019 A write SHALL occur when chipselect=1 and write_n=0; register update SHALL be visible on the next cycle.
REQ-020 When a clear-write and a new edge_det hit the same edgecapture bit in the same cycle, the bit SHALL remain set (new event wins).
REQ-021 readdata bits [31:DATA_WIDTH] SHALL always read 0.
REQ-022 readdata SHALL be 0 when chipselect=0.
REQ-023 irq SHALL be the registered OR-reduction of (edge_cap & irqmask): it rises 1 cycle after the bit sets and falls 1 cycle after the clear.

Reset
REQ-024 Assertion of reset_n SHALL asynchronously clear the synchronizer, prev_q, edge_cap, irqmask and irq to 0, including mid-transfer.
REQ-025 An in_port bit that is held high through reset release SHALL be captured as a rising edge once it reaches sync_q; software clears edgecapture at initialisation.

Configuration
REQ-026 With macro NIOS2_UART_RX_PI_IRQ_EN defined, irqmask and the irq logic SHALL be built.
REQ-027 Without NIOS2_UART_RX_PI_IRQ_EN, irq SHALL be tied to 0, irqmask SHALL read 0 and its writes SHALL be ignored, and edge capture SHALL still operate.

Structure
REQ-028 Package nios2_pio_pkg SHALL hold the address constants (ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and the edge-type constants.
REQ-029 The synchronizer SHALL be a separate sub-module, nios2_pio_sync, parameterised by width and depth.

Verification
REQ-030 Reset, then read address 0 with in_port=32'hA5 -> readdata=32'hA5 within SYNC_STAGES+1 cycles, and 0 before that.
REQ-031 EDGE_TYPE=0, in_port bit3 0->1 -> edgecapture reads 32'h8; write 32'h8 to address 3 -> reads 0 next cycle.
REQ-032 irqmask=32'h8 with bit3 rising -> irq=1 one cycle after the capture; clearing edgecapture -> irq=0 one cycle later; irqmask=0 -> irq is never asserted.
REQ-033 Clear-write to bit3 in the same cycle as a new bit3 edge_det -> bit3 remains 1.
REQ-034 EDGE_TYPE=2, 1-0-1 pulse on bit0 -> edge_cap[0] set; reset_n asserted mid-pulse -> all registers and irq read 0 immediately.
REQ-035 Build without NIOS2_UART_RX_PI_IRQ_EN, write 32'hFFFF_FFFF to address 2 -> address 2 reads 0 and irq stays 0.
